// File: rtl/idma_2d_burst_splitter_pkg.sv
// Shared types for the 2D burst splitter: FSM state and default request layouts.
package idma_2d_burst_splitter_pkg;

    typedef enum logic [0:0] {IDLE, ISSUE} state_e;

    localparam int unsigned DefAddrWidth = 64;

    typedef struct packed {
        logic [DefAddrWidth-1:0] length;
        logic [DefAddrWidth-1:0] src_addr;
        logic [DefAddrWidth-1:0] dst_addr;
        logic [7:0]              opt;
    } def_burst_req_t;

    typedef struct packed {
        logic [DefAddrWidth-1:0] reps;
        logic [DefAddrWidth-1:0] src_strides;
        logic [DefAddrWidth-1:0] dst_strides;
    } def_d_req_t;

    typedef struct packed {
        def_burst_req_t   burst_req;
        def_d_req_t [0:0] d_req;
    } def_nd_req_t;

endpackage

// File: rtl/idma_2d_burst_splitter_fifo.sv
// Minimal fifo_v3-compatible FIFO (no fall-through); flush clears it synchronously.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW:0] FullCnt = (PtrW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       rd_ptr_q, wr_ptr_q;
    logic [PtrW:0]         cnt_q;
    logic                  push_ok, pop_ok;

    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage carries no reset; only pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/idma_2d_burst_splitter.sv
// Splits a 2D DMA job into strided 1D bursts and signals completion of each job's last burst.
module idma_2d_burst_splitter
    import idma_2d_burst_splitter_pkg::*;
#(
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned NumOutstanding = 8,
    parameter type         burst_req_t    = def_burst_req_t,
    parameter type         idma_nd_req_t  = def_nd_req_t
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  idma_nd_req_t nd_req_i,
    input  logic         nd_valid_i,
    output logic         nd_ready_o,
    output burst_req_t   burst_req_o,
    output logic         burst_valid_o,
    input  logic         burst_ready_i,
    input  logic         burst_rsp_valid_i,
    input  logic         backend_idle_i,
    output logic         trans_complete_o,
    output logic         idle_o
);
    state_e                 state_q;
    burst_req_t             burst_q;
    logic [AddrWidth-1:0]   src_stride_q, dst_stride_q, remaining_q;
    logic                   burst_hs, is_last;
    logic                   fifo_full, fifo_empty, fifo_head, fifo_pop;

    assign nd_ready_o    = (state_q == IDLE) && !rst_i;
    assign burst_valid_o = (state_q == ISSUE) && !fifo_full && !rst_i;
    assign burst_req_o   = burst_q;
    assign burst_hs      = burst_valid_o && burst_ready_i;
    assign is_last       = (remaining_q == AddrWidth'(1));

    // Responses arriving with nothing outstanding are dropped and raise no pulse.
    assign fifo_pop         = burst_rsp_valid_i && !rst_i;
    assign trans_complete_o = fifo_pop && !fifo_empty && fifo_head;
    assign idle_o           = (state_q == IDLE) && fifo_empty && backend_idle_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            burst_q      <= '0;
            src_stride_q <= '0;
            dst_stride_q <= '0;
            remaining_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (nd_valid_i) begin
                        burst_q      <= nd_req_i.burst_req;
                        src_stride_q <= nd_req_i.d_req[0].src_strides;
                        dst_stride_q <= nd_req_i.d_req[0].dst_strides;
                        remaining_q  <= (nd_req_i.d_req[0].reps == '0) ? AddrWidth'(1)
                                                                         : nd_req_i.d_req[0].reps;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (burst_hs) begin
                        burst_q.src_addr <= burst_q.src_addr + src_stride_q;
                        burst_q.dst_addr <= burst_q.dst_addr + dst_stride_q;
                        remaining_q      <= remaining_q - AddrWidth'(1);
                        if (is_last) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fifo_v3 #(
        .DATA_WIDTH (1),
        .DEPTH      (NumOutstanding)
    ) i_flag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (1'b1),
        .flush_i (rst_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_i  (is_last),
        .push_i  (burst_hs),
        .data_o  (fifo_head),
        .pop_i   (fifo_pop)
    );

    a_burst_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        burst_valid_o && !burst_ready_i |=> burst_valid_o && $stable(burst_req_o));

    a_rsp_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
        burst_rsp_valid_i |-> !fifo_empty);

endmodule

// File: tb/tb_idma_2d_burst_splitter.sv
// Scoreboard bench: expected bursts/completion flags queued at job accept, compared on handshake/response.
module tb_idma_2d_burst_splitter;
    import idma_2d_burst_splitter_pkg::*;

    localparam int NumOut = 8;

    logic           clk = 1'b0;
    logic           rst_i;
    def_nd_req_t    nd_req_i;
    logic           nd_valid_i, nd_ready_o;
    def_burst_req_t burst_req_o;
    logic           burst_valid_o, burst_ready_i, burst_rsp_valid_i;
    logic           backend_idle_i, trans_complete_o, idle_o;

    always #5 clk = ~clk;

    idma_2d_burst_splitter #(
        .AddrWidth      (64),
        .NumOutstanding (NumOut),
        .burst_req_t    (def_burst_req_t),
        .idma_nd_req_t  (def_nd_req_t)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .nd_req_i          (nd_req_i),
        .nd_valid_i        (nd_valid_i),
        .nd_ready_o        (nd_ready_o),
        .burst_req_o       (burst_req_o),
        .burst_valid_o     (burst_valid_o),
        .burst_ready_i     (burst_ready_i),
        .burst_rsp_valid_i (burst_rsp_valid_i),
        .backend_idle_i    (backend_idle_i),
        .trans_complete_o  (trans_complete_o),
        .idle_o            (idle_o)
    );

    typedef struct {
        logic [63:0] src, dst, len;
        logic [7:0]  opt;
        bit          last;
    } exp_t;

    exp_t           exp_q[$];
    bit             out_q[$];
    def_nd_req_t    job_q[$];
    logic [63:0]    obs_src[$], obs_dst[$];
    int             n_tests = 0, n_fail = 0;
    int             ready_pct, rsp_pct, tc_pulses, jobs_sub;
    bit             force_rsp, prev_stall, prev_last_hs;
    def_burst_req_t stall_req;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic def_nd_req_t mk_job(input logic [63:0] reps, src, dst, ss, ds, len,
                                           input logic [7:0] opt);
        def_nd_req_t j;
        j = '0;
        j.burst_req.length       = len;
        j.burst_req.src_addr     = src;
        j.burst_req.dst_addr     = dst;
        j.burst_req.opt          = opt;
        j.d_req[0].reps          = reps;
        j.d_req[0].src_strides   = ss;
        j.d_req[0].dst_strides   = ds;
        return j;
    endfunction

    task automatic submit(input def_nd_req_t j);
        job_q.push_back(j);
        jobs_sub++;
    endtask

    task automatic expand(input def_nd_req_t j);
        int          n;
        logic [63:0] s, d;
        exp_t        e;
        n = (j.d_req[0].reps == 0) ? 1 : int'(j.d_req[0].reps);
        s = j.burst_req.src_addr;
        d = j.burst_req.dst_addr;
        for (int i = 0; i < n; i++) begin
            e.src = s; e.dst = d; e.len = j.burst_req.length; e.opt = j.burst_req.opt;
            e.last = (i == n - 1);
            exp_q.push_back(e);
            s = s + j.d_req[0].src_strides;
            d = d + j.d_req[0].dst_strides;
        end
    endtask

    // One clock: drive after posedge, observe at negedge, return to posedge+1.
    task automatic cycle();
        exp_t e;
        bit   fl;
        nd_valid_i = (job_q.size() > 0);
        if (job_q.size() > 0) nd_req_i = job_q[0];
        burst_ready_i = ($urandom_range(99) < ready_pct);
        burst_rsp_valid_i = (out_q.size() > 0) && (force_rsp || ($urandom_range(99) < rsp_pct));
        force_rsp = 1'b0;
        @(negedge clk);
        if (prev_stall) begin
            check("stall_vld", burst_valid_o, 1);
            check("stall_src", burst_req_o.src_addr, stall_req.src_addr);
            check("stall_dst", burst_req_o.dst_addr, stall_req.dst_addr);
        end
        if (prev_last_hs) check("rdy_after_last", nd_ready_o, 1);
        if (out_q.size() == NumOut) check("full_blocks", burst_valid_o, 0);
        if (burst_rsp_valid_i) begin
            fl = out_q.pop_front();
            check("tc", trans_complete_o, fl);
        end else if (trans_complete_o) begin
            check("tc_spurious", trans_complete_o, 0);
        end
        if (trans_complete_o) tc_pulses++;
        prev_last_hs = 1'b0;
        if (burst_valid_o && burst_ready_i) begin
            if (exp_q.size() == 0) begin
                check("burst_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("b_src", burst_req_o.src_addr, e.src);
                check("b_dst", burst_req_o.dst_addr, e.dst);
                check("b_len", burst_req_o.length, e.len);
                check("b_opt", burst_req_o.opt, e.opt);
                out_q.push_back(e.last);
                prev_last_hs = e.last;
                obs_src.push_back(burst_req_o.src_addr);
                obs_dst.push_back(burst_req_o.dst_addr);
            end
        end
        prev_stall = burst_valid_o && !burst_ready_i;
        stall_req  = burst_req_o;
        if (nd_valid_i && nd_ready_o) expand(job_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic new_test();
        tc_pulses = 0;
        jobs_sub  = 0;
        obs_src.delete();
        obs_dst.delete();
    endtask

    task automatic drain(input int max_cyc);
        int k = 0;
        rsp_pct = 100;
        while ((job_q.size() > 0 || exp_q.size() > 0 || out_q.size() > 0) && k < max_cyc) begin
            cycle();
            k++;
        end
        check("drain_timeout", (k < max_cyc), 1);
        run(2);
        check("idle_after_drain", idle_o, 1);
        check("tc_per_job", tc_pulses, jobs_sub);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; nd_valid_i = 1'b0; nd_req_i = '0; burst_ready_i = 1'b0;
        burst_rsp_valid_i = 1'b0; backend_idle_i = 1'b1; force_rsp = 1'b0;
        prev_stall = 1'b0; prev_last_hs = 1'b0; ready_pct = 100; rsp_pct = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_vld", burst_valid_o, 0);
        check("rst_rdy", nd_ready_o, 0);
        check("rst_tc", trans_complete_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", nd_ready_o, 1);
        check("post_rst_idle", idle_o, 1);
        check("post_rst_vld", burst_valid_o, 0);
        @(posedge clk); #1;

        // Basic 3-rep job, back-to-back bursts, responses afterwards
        new_test(); ready_pct = 100; rsp_pct = 0;
        submit(mk_job(3, 64'h1000, 64'h8000, 64'h100, 64'h40, 64, 8'h5a));
        run(4);
        check("t1_nbursts", obs_src.size(), 3);
        if (obs_src.size() == 3) begin
            check("t1_src0", obs_src[0], 64'h1000);
            check("t1_src1", obs_src[1], 64'h1100);
            check("t1_src2", obs_src[2], 64'h1200);
            check("t1_dst0", obs_dst[0], 64'h8000);
            check("t1_dst1", obs_dst[1], 64'h8040);
            check("t1_dst2", obs_dst[2], 64'h8080);
        end
        check("t1_no_early_tc", tc_pulses, 0);
        drain(50);

        // reps 0 and reps 1 each yield one burst
        new_test(); ready_pct = 100; rsp_pct = 100;
        submit(mk_job(0, 64'h2000, 64'h3000, 64'h10, 64'h10, 8, 8'h01));
        submit(mk_job(1, 64'h4000, 64'h5000, 64'h10, 64'h10, 8, 8'h02));
        drain(50);
        check("t2_nbursts", obs_src.size(), 2);

        // Outstanding limit
        new_test(); ready_pct = 100; rsp_pct = 0;
        submit(mk_job(20, 64'h0, 64'h100000, 64'h40, 64'h40, 64, 8'h7));
        run(15);
        check("t3_cap_bursts", obs_src.size(), NumOut);
        check("t3_cap_vld", burst_valid_o, 0);
        force_rsp = 1'b1;
        cycle();
        run(5);
        check("t3_one_more", obs_src.size(), NumOut + 1);
        check("t3_occ", out_q.size(), NumOut);
        drain(300);
        check("t3_total", obs_src.size(), 20);

        // Address wrap and negative stride
        new_test(); ready_pct = 100; rsp_pct = 100;
        submit(mk_job(2, 64'hFFFF_FFFF_FFFF_FF00, 64'h1000, 64'h200, 64'hFFFF_FFFF_FFFF_FFC0, 16, 8'h3));
        drain(50);
        if (obs_src.size() == 2) begin
            check("t4_src_wrap", obs_src[1], 64'h100);
            check("t4_dst_neg", obs_dst[1], 64'h0FC0);
        end else begin
            check("t4_nbursts", obs_src.size(), 2);
        end

        // Random backpressure and responses
        new_test(); ready_pct = 50; rsp_pct = 40;
        for (int j = 0; j < 6; j++)
            submit(mk_job(64'($urandom_range(12)), {$urandom(), $urandom()}, {$urandom(), $urandom()},
                          {$urandom(), $urandom()}, {$urandom(), $urandom()},
                          64'($urandom_range(255)), 8'($urandom())));
        run(60);
        ready_pct = 70;
        drain(3000);

        // Reset with bursts outstanding
        new_test(); ready_pct = 100; rsp_pct = 0;
        submit(mk_job(10, 64'h9000, 64'hA000, 64'h8, 64'h8, 32, 8'h9));
        run(3);
        check("t6_outstanding", out_q.size(), 2);
        rst_i = 1'b1; backend_idle_i = 1'b0; burst_rsp_valid_i = 1'b0;
        @(negedge clk);
        check("t6_rst_vld", burst_valid_o, 0);
        check("t6_rst_rdy", nd_ready_o, 0);
        check("t6_rst_tc", trans_complete_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        exp_q.delete(); out_q.delete(); job_q.delete();
        prev_stall = 1'b0; prev_last_hs = 1'b0;
        @(negedge clk);
        check("t6_vld", burst_valid_o, 0);
        check("t6_rdy", nd_ready_o, 1);
        check("t6_idle_busy_be", idle_o, 0);
        check("t6_tc", trans_complete_o, 0);
        @(posedge clk); #1;
        backend_idle_i = 1'b1;
        @(negedge clk);
        check("t6_idle", idle_o, 1);
        @(posedge clk); #1;
        new_test(); ready_pct = 100; rsp_pct = 100;
        submit(mk_job(1, 64'hB000, 64'hC000, 64'h0, 64'h0, 4, 8'h1));
        drain(50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
